// File: rtl/multicore_arb_pkg.sv
// Shared types and default widths for the multicore memory arbiter.
package multicore_arb_pkg;

    typedef enum logic [1:0] {
        FREE   = 2'd0,
        BUSY   = 2'd1,
        ACCESS = 2'd2,
        ERROR  = 2'd3
    } ramstate_t;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } arb_state_t;

    localparam int DEF_AW = 32;
    localparam int DEF_DW = 32;
    localparam int DEF_CW = 16;

endpackage

// File: rtl/multicore_mem_arbiter_rr_picker.sv
// Combinational round-robin picker: first requester at or after ptr, modulo NCPU.
module rr_picker #(
    parameter int NCPU = 2,
    parameter int PW   = $clog2(NCPU)
) (
    input  logic [NCPU-1:0] req,
    input  logic [PW-1:0]   ptr,
    output logic [PW-1:0]   gnt,
    output logic            any
);

    int idx;

    // Walk offsets from farthest to nearest so the nearest requester wins.
    always_comb begin
        gnt = '0;
        any = |req;
        idx = 0;
        for (int k = NCPU - 1; k >= 0; k--) begin
            idx = int'(ptr) + k;
            if (idx >= NCPU) idx = idx - NCPU;
            if (req[idx]) gnt = PW'(idx);
        end
    end

endmodule

// File: rtl/multicore_mem_arbiter.sv
// N-core round-robin arbiter onto a single RAM port, plus registered halt aggregation.
// Optional per-core completion counters are enabled with macro ARB_STATS_EN.
module multicore_mem_arbiter
    import multicore_arb_pkg::*;
#(
    parameter int NCPU = 2,
    parameter int AW   = DEF_AW,
    parameter int DW   = DEF_DW,
    parameter int CW   = DEF_CW
) (
    input  logic                     CLK,
    input  logic                     RST,
    input  logic [NCPU-1:0]          req_ren,
    input  logic [NCPU-1:0]          req_wen,
    input  logic [NCPU-1:0][AW-1:0]  req_addr,
    input  logic [NCPU-1:0][DW-1:0]  req_store,
    output logic [NCPU-1:0]          req_wait,
    output logic [DW-1:0]            req_load,
    input  logic [NCPU-1:0]          flushed,
    output logic                     halt,
    output logic [AW-1:0]            ramaddr,
    output logic [DW-1:0]            ramstore,
    output logic                     ramREN,
    output logic                     ramWEN,
    input  logic [DW-1:0]            ramload,
    input  logic [1:0]               ramstate
`ifdef ARB_STATS_EN
    ,
    output logic [NCPU-1:0][CW-1:0]  grant_count
`endif
);

    localparam int PW = $clog2(NCPU);

    arb_state_t      state, state_n;
    logic [PW-1:0]   ptr, ptr_n, gnt, gnt_n, pick;
    logic [NCPU-1:0] req;
    logic            any;
    ramstate_t       rs;

    assign req      = req_ren | req_wen;
    assign rs       = ramstate_t'(ramstate);
    assign req_load = ramload;

    rr_picker #(.NCPU(NCPU), .PW(PW)) u_pick (
        .req (req),
        .ptr (ptr),
        .gnt (pick),
        .any (any)
    );

    always_ff @(posedge CLK) begin
        if (RST) begin
            state <= IDLE;
            ptr   <= '0;
            gnt   <= '0;
            halt  <= 1'b0;
        end else begin
            state <= state_n;
            ptr   <= ptr_n;
            gnt   <= gnt_n;
            halt  <= &flushed;
        end
    end

    always_comb begin
        state_n  = state;
        ptr_n    = ptr;
        gnt_n    = gnt;
        ramaddr  = '0;
        ramstore = '0;
        ramREN   = 1'b0;
        ramWEN   = 1'b0;
        req_wait = '1;
        case (state)
            IDLE: begin
                if (any) begin
                    gnt_n   = pick;
                    state_n = GRANT;
                end
            end
            GRANT: begin
                ramaddr  = req_addr[gnt];
                ramstore = req_store[gnt];
                ramWEN   = req_wen[gnt];
                ramREN   = req_ren[gnt] & ~req_wen[gnt];
                // A withdrawn request abandons the slot without advancing fairness.
                if (!req[gnt]) begin
                    state_n = IDLE;
                end else if (rs == ACCESS) begin
                    req_wait[gnt] = 1'b0;
                    ptr_n         = (gnt == PW'(NCPU - 1)) ? '0 : gnt + 1'b1;
                    state_n       = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

`ifdef ARB_STATS_EN
    always_ff @(posedge CLK) begin
        if (RST) begin
            grant_count <= '0;
        end else if (state == GRANT && req[gnt] && rs == ACCESS) begin
            for (int i = 0; i < NCPU; i++) begin
                if (gnt == PW'(i) && grant_count[i] != '1)
                    grant_count[i] <= grant_count[i] + 1'b1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_multicore_mem_arbiter.sv
// Directed self-checking bench for multicore_mem_arbiter with NCPU=4.
module tb_multicore_mem_arbiter;
    import multicore_arb_pkg::*;

    localparam int NCPU = 4;
    localparam int AW   = 32;
    localparam int DW   = 32;
    localparam int CW   = 16;

    logic                    CLK, RST;
    logic [NCPU-1:0]         req_ren, req_wen, req_wait, flushed;
    logic [NCPU-1:0][AW-1:0] req_addr;
    logic [NCPU-1:0][DW-1:0] req_store;
    logic [DW-1:0]           req_load, ramstore, ramload;
    logic [AW-1:0]           ramaddr;
    logic                    halt, ramREN, ramWEN;
    logic [1:0]              ramstate;
`ifdef ARB_STATS_EN
    logic [NCPU-1:0][CW-1:0] grant_count;
`endif

    int n_err = 0;
    int n_checks = 0;

    multicore_mem_arbiter #(.NCPU(NCPU), .AW(AW), .DW(DW), .CW(CW)) dut (
        .CLK(CLK), .RST(RST),
        .req_ren(req_ren), .req_wen(req_wen), .req_addr(req_addr), .req_store(req_store),
        .req_wait(req_wait), .req_load(req_load),
        .flushed(flushed), .halt(halt),
        .ramaddr(ramaddr), .ramstore(ramstore), .ramREN(ramREN), .ramWEN(ramWEN),
        .ramload(ramload), .ramstate(ramstate)
`ifdef ARB_STATS_EN
        , .grant_count(grant_count)
`endif
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
        n_checks++;
        assert (obs === exp_v) else begin
            n_err++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp_v);
        end
    endtask

    initial begin
        RST = 1'b1; req_ren = '0; req_wen = '0; req_addr = '0; req_store = '0;
        flushed = '0; ramload = '0; ramstate = FREE;
        tick(); tick(); #1;
        chk("rst_ren",  64'(ramREN),   0);
        chk("rst_wen",  64'(ramWEN),   0);
        chk("rst_wait", 64'(req_wait), 64'hF);
        chk("rst_halt", 64'(halt),     0);
        chk("rst_addr", 64'(ramaddr),  0);
        RST = 1'b0;

        // single read with two BUSY cycles
        req_ren = 4'b0001; req_addr[0] = 32'h40; ramstate = BUSY; #1;
        chk("t1_idle_ren", 64'(ramREN), 0);
        for (int c = 0; c < 2; c++) begin
            tick(); #1;
            chk("t1_busy_ren",  64'(ramREN),   1);
            chk("t1_busy_addr", 64'(ramaddr),  64'h40);
            chk("t1_busy_wait", 64'(req_wait), 64'hF);
        end
        ramstate = ACCESS; ramload = 32'hDEADBEEF; #1;
        chk("t1_acc_ren",  64'(ramREN),   1);
        chk("t1_acc_addr", 64'(ramaddr),  64'h40);
        chk("t1_acc_wait", 64'(req_wait), 64'hE);
        chk("t1_acc_load", 64'(req_load), 64'hDEADBEEF);
        tick(); req_ren = '0; ramstate = FREE; #1;
        chk("t1_post_ren",  64'(ramREN),   0);
        chk("t1_post_wait", 64'(req_wait), 64'hF);

        // core1 with both enables: write wins (ptr is 1 now)
        req_ren = 4'b0010; req_wen = 4'b0010; req_addr[1] = 32'h80; req_store[1] = 32'h1234;
        tick(); ramstate = ACCESS; #1;
        chk("t3_wen",   64'(ramWEN),   1);
        chk("t3_ren",   64'(ramREN),   0);
        chk("t3_store", 64'(ramstore), 64'h1234);
        chk("t3_addr",  64'(ramaddr),  64'h80);
        chk("t3_wait",  64'(req_wait), 64'hD);
        tick(); req_ren = '0; req_wen = '0; ramstate = FREE;

        // reset while core2 holds the grant (ptr is 2 now)
        req_ren = 4'b0100; req_addr[2] = 32'h20; ramstate = BUSY;
        tick(); #1;
        chk("t5_pre_ren",  64'(ramREN),  1);
        chk("t5_pre_addr", 64'(ramaddr), 64'h20);
        RST = 1'b1;
        tick();
        RST = 1'b0; req_ren = 4'b0101; req_addr[0] = 32'h10; #1;
        chk("t5_rst_ren",  64'(ramREN),   0);
        chk("t5_rst_wen",  64'(ramWEN),   0);
        chk("t5_rst_wait", 64'(req_wait), 64'hF);
        tick(); #1;
        chk("t5_fresh_addr", 64'(ramaddr), 64'h10);
        chk("t5_fresh_wait", 64'(req_wait), 64'hF);

        // core0 withdraws before ACCESS; core1 takes the next grant
        req_ren = 4'b0110; #1;
        chk("t4_drop_ren",  64'(ramREN),   0);
        chk("t4_drop_wait", 64'(req_wait), 64'hF);
        tick(); #1;
        chk("t4_idle_ren", 64'(ramREN), 0);
        tick(); #1;
        chk("t4_next_addr", 64'(ramaddr), 64'h80);
        chk("t4_next_ren",  64'(ramREN),  1);
        ramstate = ACCESS; #1;
        chk("t4_next_wait", 64'(req_wait), 64'hD);
        tick(); req_ren = '0; ramstate = FREE;

        // all four contend after reset; core0 re-granted after core3
        RST = 1'b1; tick(); RST = 1'b0;
        for (int i = 0; i < NCPU; i++) req_addr[i] = 32'h100 + 32'(4 * i);
        req_ren = 4'hF; ramstate = ACCESS;
        for (int k = 0; k < 5; k++) begin
            tick(); #1;
            chk($sformatf("t2_addr%0d", k), 64'(ramaddr), 64'(32'h100 + 32'(4 * (k % 4))));
            chk($sformatf("t2_wait%0d", k), 64'(req_wait), 64'(4'hF & ~(4'b0001 << (k % 4))));
            tick(); #1;
            chk($sformatf("t2_idle%0d", k), 64'(req_wait), 64'hF);
        end
`ifdef ARB_STATS_EN
        chk("cnt0", 64'(grant_count[0]), 2);
        chk("cnt1", 64'(grant_count[1]), 1);
        chk("cnt2", 64'(grant_count[2]), 1);
        chk("cnt3", 64'(grant_count[3]), 1);
`endif
        req_ren = '0; ramstate = FREE;

        // halt follows AND of flushed one cycle later, never sticky
        flushed = 4'hF; #1;
        chk("t6_halt_pre", 64'(halt), 0);
        tick(); #1;
        chk("t6_halt_set", 64'(halt), 1);
        flushed = 4'b1101; #1;
        chk("t6_halt_hold", 64'(halt), 1);
        tick(); #1;
        chk("t6_halt_clr", 64'(halt), 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
